wfg_core_multi: RTL and testbench
=================================

// Module: wfg_core_multi
// PURPOSE
// - Multi-channel successor of the waveform-generator core timing block.
// - NCH independent timing channels, each configured over Wishbone.
// - Each channel emits start, subcycle and sync pulses plus a subcycle count,
//   which downstream pattern/driver blocks consume per channel.
// PARAMETERS
// - BUSW   32  Wishbone data/address width
// - NCH    2   channel count, 1..8
// - CNTW   16  subcycle prescaler width, 1..BUSW
// - SYNCW  8   subcycle counter width, 1..BUSW
// PORTS
// - wb_clk_i                I  1          single clock
// - wb_rst_i                I  1          synchronous reset, active-high
// - wbs_stb_i, wbs_cyc_i    I  1          Wishbone strobe, cycle
// - wbs_we_i                I  1          write enable
// - wbs_sel_i               I  4          byte selects; ignored, always full-word access
// - wbs_dat_i, wbs_adr_i    I  BUSW       write data, byte address (bits [7:0] decoded)
// - wbs_ack_o               O  1          acknowledge
// - wbs_dat_o               O  BUSW       read data
// - wfg_pat_sync_o          O  NCH        per-channel sync pulse
// - wfg_pat_subcycle_o      O  NCH        per-channel subcycle pulse
// - wfg_pat_start_o         O  NCH        per-channel start pulse
// - wfg_pat_subcycle_cnt_o  O  NCH*SYNCW  channel ch at [ch*SYNCW +: SYNCW]
// - active_o                O  NCH        per-channel active
// BEHAVIOUR
// - Reset: all registers 0 and all outputs 0, including ack and dat_o.
// - Wishbone bus:
//   - ack is 1 cycle after stb&cyc, high for exactly 1 cycle.
//   - No new ack in the cycle following an ack.
//   - A write commits on the ack edge.
//   - Reads return the registered value; unmapped reads return 0; unmapped writes are ignored.
// - Register map:
//   - 0x00 CTRL    [NCH-1:0] en, RW
//   - 0x04 STATUS  [NCH-1:0] active, RO
//   - 0x10+0x10*ch SUBCYC [CNTW-1:0] RW, ch = channel index
//   - 0x14+0x10*ch SYNC   [SYNCW-1:0] RW
//   - 0x18+0x10*ch PHASE  [CNTW-1:0] RW, only with the macro below
// - Per channel, en low:
//   - Prescaler pc=0, subcycle counter scnt=0.
//   - All pulses 0 and active_o=0, taking effect the cycle after en clears, even mid-period.
// - en 0->1, first active cycle T1:
//   - active_o=1 and start_o=1 for T1 only.
//   - The shadow registers load SUBCYC and SYNC.
// - Prescaler while active: pc==shadow_subcyc -> pc<=0 and subcycle_o pulses 1 cycle later;
//   otherwise pc++. Period is SUBCYC+1 clocks.
// - Subcycle counter, advanced on each subcycle pulse:
//   - scnt==shadow_sync -> scnt<=0 and sync_o pulses together with that subcycle_o; otherwise scnt++.
//   - Sync period is SYNC+1 subcycles.
//   - subcycle_cnt_o = scnt, registered.
// - Shadow reload: SUBCYC/SYNC writes while active take effect at the next prescaler
//   wrap / sync wrap respectively, never mid-period.
// - Boundaries:
//   - SUBCYC=0: subcycle_o high every active cycle.
//   - SYNC=0: sync_o equals subcycle_o.
//   - All-ones values wrap without overflow.
// - Channels that are enabled in the same CTRL write start on the same cycle and stay
//   phase-aligned while their configs are equal.
// - Reset asserted mid-operation overrides everything next cycle, including a pending ack.
// CONFIGURATION
// - WFG_CORE_PHASE_EN defined:
//   - PHASE registers exist.
//   - On enable, pc loads PHASE (clamped to SUBCYC), so the first subcycle comes after
//     SUBCYC-PHASE+1 clocks; later periods are unchanged.
// - WFG_CORE_PHASE_EN undefined:
//   - PHASE addresses are unmapped and read 0.
//   - pc loads 0 on enable.
// TESTING
// - Reset:
//   - Assert wb_rst_i for 2 cycles -> all outputs 0.
//   - Read 0x00, 0x04, 0x10 -> 0; each access acks after 1 cycle.
// - ch0 SUBCYC=3, SYNC=2, CTRL=1:
//   - start_o[0] pulses once.
//   - subcycle_o[0] pulses every 4 clocks; sync_o[0] every 12 clocks.
//   - subcycle_cnt follows 0,1,2,0.
// - ch0 and ch1 with SUBCYC=0/SYNC=0 and 5/1, enabled by a single CTRL=3 write:
//   - start pulses coincide.
//   - ch0 subcycle=sync=1 on every cycle; ch1 sync every 12 clocks.
// - Mid-run update and disable:
//   - Write SUBCYC 3->7 mid-period -> the current period stays 4 clocks, the next is 8.
//   - Write CTRL=0 -> active_o 0 and no further pulses from the next cycle.
//   - STATUS reads 0.
// - Reset mid-run with SUBCYC=0xFFFF:
//   - Full-width wrap produces a subcycle pulse after 65536 clocks.
//   - Reset mid-count clears pc, scnt and outputs.
// - WFG_CORE_PHASE_EN with SUBCYC=7, PHASE=5:
//   - First subcycle comes 3 clocks after enable, then every 8.
//   - Without the macro, 0x18 reads 0.

Source files
------------

// File: rtl/wfg_core_multi.sv
// wfg_core_multi: NCH independent waveform timing channels behind a Wishbone register file.
// Optional feature macro WFG_CORE_PHASE_EN adds per-channel PHASE registers (start offset).
`timescale 1ns/1ps
module wfg_core_multi #(
  parameter int BUSW  = 32,
  parameter int NCH   = 2,
  parameter int CNTW  = 16,
  parameter int SYNCW = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [BUSW-1:0]       wbs_dat_i,
  input  logic [BUSW-1:0]       wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [BUSW-1:0]       wbs_dat_o,
  output logic [NCH-1:0]        wfg_pat_sync_o,
  output logic [NCH-1:0]        wfg_pat_subcycle_o,
  output logic [NCH-1:0]        wfg_pat_start_o,
  output logic [NCH*SYNCW-1:0]  wfg_pat_subcycle_cnt_o,
  output logic [NCH-1:0]        active_o
);

  logic                 ack_q;
  logic [BUSW-1:0]      dat_q;
  logic [BUSW-1:0]      rd_d;
  logic [NCH-1:0]       en_q;
  logic [CNTW-1:0]      subcyc_q [NCH];
  logic [SYNCW-1:0]     syncw_q  [NCH];
`ifdef WFG_CORE_PHASE_EN
  logic [CNTW-1:0]      phase_q  [NCH];
  logic [NCH-1:0]       wr_phase;
`endif
  logic                 req;
  logic [7:0]           adr;
  logic                 wr_ctrl;
  logic [NCH-1:0]       wr_sub;
  logic [NCH-1:0]       wr_sync;
  logic                 unused_ok;

  // Handshake: a request is stb&cyc while no ack is outstanding; ack_q rises on the
  // next edge for one cycle, the write commits on that same edge, and read data is
  // registered alongside it. The cycle after an ack never acks.
  assign req       = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign adr       = wbs_adr_i[7:0];
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[BUSW-1:8], wbs_dat_i};

  always_comb begin
    rd_d     = '0;
    wr_ctrl  = req & wbs_we_i & (adr == 8'h00);
    wr_sub   = '0;
    wr_sync  = '0;
`ifdef WFG_CORE_PHASE_EN
    wr_phase = '0;
`endif
    if (adr == 8'h00) rd_d[NCH-1:0] = en_q;
    if (adr == 8'h04) rd_d[NCH-1:0] = active_o;
    for (int ch = 0; ch < NCH; ch++) begin
      if (adr == 8'((ch + 1) * 16)) begin
        rd_d[CNTW-1:0] = subcyc_q[ch];
        wr_sub[ch]     = req & wbs_we_i;
      end
      if (adr == 8'((ch + 1) * 16 + 4)) begin
        rd_d[SYNCW-1:0] = syncw_q[ch];
        wr_sync[ch]     = req & wbs_we_i;
      end
`ifdef WFG_CORE_PHASE_EN
      if (adr == 8'((ch + 1) * 16 + 8)) begin
        rd_d[CNTW-1:0] = phase_q[ch];
        wr_phase[ch]   = req & wbs_we_i;
      end
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      en_q  <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        subcyc_q[ch] <= '0;
        syncw_q[ch]  <= '0;
`ifdef WFG_CORE_PHASE_EN
        phase_q[ch]  <= '0;
`endif
      end
    end else begin
      ack_q <= req;
      dat_q <= req ? rd_d : '0;
      if (wr_ctrl) en_q <= wbs_dat_i[NCH-1:0];
      for (int ch = 0; ch < NCH; ch++) begin
        if (wr_sub[ch])   subcyc_q[ch] <= wbs_dat_i[CNTW-1:0];
        if (wr_sync[ch])  syncw_q[ch]  <= wbs_dat_i[SYNCW-1:0];
`ifdef WFG_CORE_PHASE_EN
        if (wr_phase[ch]) phase_q[ch]  <= wbs_dat_i[CNTW-1:0];
`endif
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic             active_q;
    logic             start_q;
    logic             sub_q;
    logic             syncp_q;
    logic [CNTW-1:0]  pc_q;
    logic [CNTW-1:0]  sh_sub_q;
    logic [CNTW-1:0]  pc_init;
    logic [SYNCW-1:0] scnt_q;
    logic [SYNCW-1:0] sh_sync_q;

`ifdef WFG_CORE_PHASE_EN
    assign pc_init = (phase_q[g] > subcyc_q[g]) ? subcyc_q[g] : phase_q[g];
`else
    assign pc_init = '0;
`endif

    // Shadows only reload at their own wrap, so config writes never cut a period short.
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        active_q  <= 1'b0;
        start_q   <= 1'b0;
        sub_q     <= 1'b0;
        syncp_q   <= 1'b0;
        pc_q      <= '0;
        scnt_q    <= '0;
        sh_sub_q  <= '0;
        sh_sync_q <= '0;
      end else if (!en_q[g]) begin
        active_q  <= 1'b0;
        start_q   <= 1'b0;
        sub_q     <= 1'b0;
        syncp_q   <= 1'b0;
        pc_q      <= '0;
        scnt_q    <= '0;
      end else if (!active_q) begin
        active_q  <= 1'b1;
        start_q   <= 1'b1;
        sub_q     <= 1'b0;
        syncp_q   <= 1'b0;
        pc_q      <= pc_init;
        scnt_q    <= '0;
        sh_sub_q  <= subcyc_q[g];
        sh_sync_q <= syncw_q[g];
      end else begin
        start_q <= 1'b0;
        if (pc_q == sh_sub_q) begin
          pc_q     <= '0;
          sub_q    <= 1'b1;
          sh_sub_q <= subcyc_q[g];
          if (scnt_q == sh_sync_q) begin
            scnt_q    <= '0;
            syncp_q   <= 1'b1;
            sh_sync_q <= syncw_q[g];
          end else begin
            scnt_q  <= scnt_q + SYNCW'(1);
            syncp_q <= 1'b0;
          end
        end else begin
          pc_q    <= pc_q + CNTW'(1);
          sub_q   <= 1'b0;
          syncp_q <= 1'b0;
        end
      end
    end

    assign active_o[g]                              = active_q;
    assign wfg_pat_start_o[g]                       = start_q;
    assign wfg_pat_subcycle_o[g]                    = sub_q;
    assign wfg_pat_sync_o[g]                        = syncp_q;
    assign wfg_pat_subcycle_cnt_o[g*SYNCW +: SYNCW] = scnt_q;
  end

endmodule

// File: tb/tb_wfg_core_multi.sv
// Bench for wfg_core_multi: register bus, per-channel pulse timing, shadow reload, reset.
// Pulse events are logged by a monitor and scored against an expected queue.
`timescale 1ns/1ps
module tb_wfg_core_multi;
  localparam int BUSW = 32, NCH = 2, CNTW = 16, SYNCW = 8;

  logic              clk;
  logic              rst;
  logic              stb, cyc_i, we;
  logic [3:0]        sel;
  logic [BUSW-1:0]   adr, dat_i;
  logic              ack;
  logic [BUSW-1:0]   dat_o;
  logic [NCH-1:0]    sync_o, sub_o, start_o, active_o;
  logic [NCH*SYNCW-1:0] cnt_o;

  logic [31:0] exp_q[$];
  logic [31:0] ev_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          cfg_s [NCH];
  int          cfg_y [NCH];
  int          cfg_f [NCH];
  bit          cfg_on[NCH];

  wfg_core_multi #(.BUSW(BUSW), .NCH(NCH), .CNTW(CNTW), .SYNCW(SYNCW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc_i), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .wfg_pat_sync_o(sync_o), .wfg_pat_subcycle_o(sub_o), .wfg_pat_start_o(start_o),
    .wfg_pat_subcycle_cnt_o(cnt_o), .active_o(active_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  function automatic logic [31:0] ev(input int kind, input int ch, input int cnt, input int t);
    return {4'(kind), 4'(ch), 8'(cnt), 16'(t)};
  endfunction

  always @(negedge clk) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (start_o[ch] === 1'b1) ev_q.push_back(ev(1, ch, 0, cyc));
      if (sub_o[ch] === 1'b1)   ev_q.push_back(ev(2, ch, int'(cnt_o[ch*SYNCW +: SYNCW]), cyc));
      if (sync_o[ch] === 1'b1)  ev_q.push_back(ev(3, ch, 0, cyc));
    end
  end

  // Expected events from closed-form timing: start at c+1, first subcycle at c+1+F,
  // then every S+1 clocks; k-th subcycle carries count k mod (Y+1), sync when 0.
  task automatic build_exp(input int c, input int d);
    for (int t = c + 1; t <= d; t++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (cfg_on[ch]) begin
          int first, k, n;
          first = c + 1 + cfg_f[ch];
          if (t == c + 1) exp_q.push_back(ev(1, ch, 0, t));
          if (t >= first && ((t - first) % (cfg_s[ch] + 1)) == 0) begin
            k = (t - first) / (cfg_s[ch] + 1) + 1;
            n = k % (cfg_y[ch] + 1);
            exp_q.push_back(ev(2, ch, n, t));
            if (n == 0) exp_q.push_back(ev(3, ch, 0, t));
          end
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, output int c);
    @(negedge clk);
    stb = 1'b1; cyc_i = 1'b1; we = 1'b1; adr = a; dat_i = d;
    c = -1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin c = cyc; break; end
    end
    stb = 1'b0; cyc_i = 1'b0; we = 1'b0;
    if (c < 0) begin
      total++; bad++;
      $display("FAIL wb_write_ack addr=%h got=no_ack exp=ack", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    @(negedge clk);
    stb = 1'b1; cyc_i = 1'b1; we = 1'b0; adr = a;
    lat = 0; d = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin lat = k + 1; d = dat_o; break; end
    end
    stb = 1'b0; cyc_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d, e;
    int lat;
    logic [31:0] addrs [3];
    addrs = '{32'h00, 32'h04, 32'h10};
    rst = 1'b1; stb = 0; cyc_i = 0; we = 0; sel = 4'hF; adr = 0; dat_i = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ack, dat_o} !== '0) begin bad++; $display("FAIL reset_bus got=%h exp=0", {ack, dat_o}); end
    total++;
    if ({sync_o, sub_o, start_o, active_o} !== '0) begin
      bad++; $display("FAIL reset_pulses got=%h exp=0", {sync_o, sub_o, start_o, active_o});
    end
    total++;
    if (cnt_o !== '0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", cnt_o); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      wb_read(addrs[i], d, lat);
      e = exp_q.pop_front();
      total++;
      if (d !== e) begin bad++; $display("FAIL reset_read a=%h got=%h exp=%h", addrs[i], d, e); end
      total++;
      if (lat !== 1) begin bad++; $display("FAIL reset_ack_lat a=%h got=%0d exp=1", addrs[i], lat); end
    end
  endtask

  task automatic test_bus();
    logic [2:0] acks;
    logic [31:0] d, e;
    int lat, c;
    logic [31:0] addrs [6];
    addrs = '{32'h20, 32'h24, 32'h0C, 32'h30, 32'h34, 32'h08};
    @(negedge clk);
    stb = 1'b1; cyc_i = 1'b1; we = 1'b0; adr = 32'h0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; acks[2-k] = ack; end
    stb = 1'b0; cyc_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if (acks !== 3'b101) begin bad++; $display("FAIL ack_spacing got=%b exp=101", acks); end
    wb_write(32'h20, 32'h0000_1234, c);
    wb_write(32'h24, 32'h0000_01FF, c);
    wb_write(32'h0C, 32'hFFFF_FFFF, c);
    wb_write(32'h30, 32'h0000_0007, c);
    exp_q.push_back(32'h1234); exp_q.push_back(32'hFF);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 6; i++) begin
      wb_read(addrs[i], d, lat);
      e = exp_q.pop_front();
      total++;
      if (d !== e) begin bad++; $display("FAIL bus_read a=%h got=%h exp=%h", addrs[i], d, e); end
    end
  endtask

  task automatic test_single();
    int c, d, lat;
    logic [31:0] e, o, rd;
    wb_write(32'h10, 32'd3, c);
    wb_write(32'h14, 32'd2, c);
    cfg_on = '{1, 0}; cfg_s[0] = 3; cfg_y[0] = 2; cfg_f[0] = 4;
    ev_q.delete();
    wb_write(32'h00, 32'h1, c);
    repeat (20) @(negedge clk);
    wb_read(32'h04, rd, lat);
    total++;
    if (rd !== 32'h1) begin bad++; $display("FAIL single_status got=%h exp=1", rd); end
    repeat (10) @(negedge clk);
    wb_write(32'h00, 32'h0, d);
    repeat (5) @(negedge clk);
    build_exp(c, d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      o = (ev_q.size() > 0) ? ev_q.pop_front() : 32'hFFFF_FFFF;
      if (o !== e) begin bad++; $display("FAIL single_ev got=%h exp=%h", o, e); end
    end
    total++;
    if (ev_q.size() != 0) begin bad++; $display("FAIL single_extra got=%0d exp=0", ev_q.size()); end
  endtask

  task automatic test_dual();
    int c, d;
    logic [31:0] e, o;
    wb_write(32'h10, 32'd0, c);
    wb_write(32'h14, 32'd0, c);
    wb_write(32'h20, 32'd5, c);
    wb_write(32'h24, 32'd1, c);
    cfg_on = '{1, 1};
    cfg_s = '{0, 5}; cfg_y = '{0, 1}; cfg_f = '{1, 6};
    ev_q.delete();
    wb_write(32'h00, 32'h3, c);
    repeat (30) @(negedge clk);
    wb_write(32'h00, 32'h0, d);
    repeat (5) @(negedge clk);
    build_exp(c, d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      o = (ev_q.size() > 0) ? ev_q.pop_front() : 32'hFFFF_FFFF;
      if (o !== e) begin bad++; $display("FAIL dual_ev got=%h exp=%h", o, e); end
    end
    total++;
    if (ev_q.size() != 0) begin bad++; $display("FAIL dual_extra got=%0d exp=0", ev_q.size()); end
  endtask

  task automatic test_midrun();
    int c, w, d, t, lat;
    logic [31:0] e, o, rd;
    wb_write(32'h10, 32'd3, c);
    wb_write(32'h14, 32'd0, c);
    ev_q.delete();
    wb_write(32'h00, 32'h1, c);
    while (cyc < c + 9) @(negedge clk);
    wb_write(32'h10, 32'd7, w);
    repeat (22) @(negedge clk);
    wb_write(32'h00, 32'h0, d);
    repeat (5) @(negedge clk);
    total++;
    if (active_o !== '0) begin bad++; $display("FAIL midrun_active got=%b exp=0", active_o); end
    wb_read(32'h04, rd, lat);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL midrun_status got=%h exp=0", rd); end
    exp_q.push_back(ev(1, 0, 0, c + 1));
    t = c + 5;
    while (t <= d) begin
      exp_q.push_back(ev(2, 0, 0, t));
      exp_q.push_back(ev(3, 0, 0, t));
      t += (t < c + 13) ? 4 : 8;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      o = (ev_q.size() > 0) ? ev_q.pop_front() : 32'hFFFF_FFFF;
      if (o !== e) begin bad++; $display("FAIL midrun_ev got=%h exp=%h", o, e); end
    end
    total++;
    if (ev_q.size() != 0) begin bad++; $display("FAIL midrun_extra got=%0d exp=0", ev_q.size()); end
  endtask

  task automatic test_phase();
    int c, d, lat;
    logic [31:0] e, o, rd;
    wb_write(32'h10, 32'd7, c);
    wb_write(32'h14, 32'd0, c);
    wb_write(32'h18, 32'd5, c);
`ifdef WFG_CORE_PHASE_EN
    exp_q.push_back(32'd5);
    cfg_f[0] = 3;
`else
    exp_q.push_back(32'd0);
    cfg_f[0] = 8;
`endif
    wb_read(32'h18, rd, lat);
    e = exp_q.pop_front();
    total++;
    if (rd !== e) begin bad++; $display("FAIL phase_read got=%h exp=%h", rd, e); end
    cfg_on = '{1, 0}; cfg_s[0] = 7; cfg_y[0] = 0;
    ev_q.delete();
    wb_write(32'h00, 32'h1, c);
    repeat (30) @(negedge clk);
    wb_write(32'h00, 32'h0, d);
    repeat (5) @(negedge clk);
    build_exp(c, d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      o = (ev_q.size() > 0) ? ev_q.pop_front() : 32'hFFFF_FFFF;
      if (o !== e) begin bad++; $display("FAIL phase_ev got=%h exp=%h", o, e); end
    end
    total++;
    if (ev_q.size() != 0) begin bad++; $display("FAIL phase_extra got=%0d exp=0", ev_q.size()); end
  endtask

  task automatic test_wrap_reset();
    int c, lat;
    logic [31:0] e, o, rd;
    logic [31:0] addrs [3];
    addrs = '{32'h00, 32'h04, 32'h10};
    wb_write(32'h10, 32'hFFFF, c);
    wb_write(32'h14, 32'd3, c);
    cfg_on = '{1, 0}; cfg_s[0] = 65535; cfg_y[0] = 3; cfg_f[0] = 65536;
    ev_q.delete();
    wb_write(32'h00, 32'h1, c);
    repeat (65539) @(negedge clk);
    build_exp(c, c + 65538);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      o = (ev_q.size() > 0) ? ev_q.pop_front() : 32'hFFFF_FFFF;
      if (o !== e) begin bad++; $display("FAIL wrap_ev got=%h exp=%h", o, e); end
    end
    total++;
    if (ev_q.size() != 0) begin bad++; $display("FAIL wrap_extra got=%0d exp=0", ev_q.size()); end
    repeat (10) @(negedge clk);
    total++;
    if ({active_o[0], cnt_o[SYNCW-1:0]} !== {1'b1, 8'd1}) begin
      bad++; $display("FAIL wrap_pre_reset got=%h exp=101", {active_o[0], cnt_o[SYNCW-1:0]});
    end
    // Reset lands together with a fresh bus request; the request must not be acked.
    stb = 1'b1; cyc_i = 1'b1; we = 1'b0; adr = 32'h04; rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ack, active_o, sub_o, sync_o, cnt_o} !== '0) begin
      bad++; $display("FAIL reset_mid got=%h exp=0", {ack, active_o, sub_o, sync_o, cnt_o});
    end
    @(negedge clk); stb = 1'b0; cyc_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (ev_q.size() != 0) begin bad++; $display("FAIL reset_quiet got=%0d exp=0", ev_q.size()); end
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      wb_read(addrs[i], rd, lat);
      e = exp_q.pop_front();
      total++;
      if (rd !== e) begin bad++; $display("FAIL reset_mid_read a=%h got=%h exp=%h", addrs[i], rd, e); end
    end
  endtask

  initial begin
    test_reset();
    test_bus();
    test_single();
    test_dual();
    test_midrun();
    test_phase();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
